// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Drives a 4-digit common-anode 7-segment display from a 16-bit bus of four
// hex nibbles. data_in[15:12] is the leftmost digit (digit 3) and
// data_in[3:0] is the rightmost digit (digit 0). One digit is lit at a time,
// and the digits are scanned in the order 0 -> 1 -> 2 -> 3.
//
// The bus is snapshotted once per scan frame, at the end of the digit 3 slot.
// Because of this, a change on the bus in the middle of a frame never tears
// the image: it only becomes visible in the next frame.
//
// Every digit slot begins with BLANK_CYC cycles during which all anodes are
// off. This removes ghosting, and it means that two anodes are never active
// at the same time.
//
// Parameters
//   SCAN_DIV   : clk cycles per digit slot (>= 4)
//   BLANK_CYC  : dark cycles at the start of each slot (< SCAN_DIV)
//
// Optional feature (compile-time macro)
//   LEADING_ZERO_BLANK_EN : when defined, digits 3..1 are blanked if their
//     nibble is zero, all higher nibbles are zero, and their own decimal
//     point is off. Digit 0 is never blanked.
//
// Ports
//   clk        in   1   system clock
//   clr        in   1   asynchronous active-high reset
//   data_in    in  16   four hex nibbles, nibble k -> digit k
//   dp_in      in   4   decimal point per digit, active-high
//   an         out  4   digit anodes, active-low, at most one low
//   seg        out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp         out  1   decimal point, active-low
//   frame_done out  1   one-cycle pulse when the snapshot reloads
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned     CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    // Digit slot being scanned; the encoding equals the digit index.
    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_t;

    // -------------------------------------------------------------------------
    // Hex to active-low segment decoder, bit order {g,f,e,d,c,b,a}
    // -------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // State and wires
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    digit_t           r_digit;
    digit_t           w_digit_next;
    logic             w_tick;
    logic             w_frame_end;

    logic [15:0]      r_shadow;
    logic [3:0]       r_shadow_dp;

    logic [1:0]       w_idx;
    logic [3:0]       w_nib;
    logic             w_dp_bit;
    logic [3:0]       w_lz_mask;

    logic [3:0]       w_an_next;
    logic [6:0]       w_seg_next;
    logic             w_dp_next;

    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_frame_done;

    assign w_tick      = (r_cnt == CNT_LAST);
    assign w_frame_end = w_tick && (r_digit == DIG3);

    // -------------------------------------------------------------------------
    // Slot counter: free-running from 0 to SCAN_DIV-1
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Digit FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_digit <= DIG0;
        end else begin
            r_digit <= w_digit_next;
        end
    end

    // -------------------------------------------------------------------------
    // Digit FSM: next-state logic; the state advances only on a slot tick
    // -------------------------------------------------------------------------
    always_comb begin
        w_digit_next = r_digit;
        if (w_tick) begin
            unique case (r_digit)
                DIG0:    w_digit_next = DIG1;
                DIG1:    w_digit_next = DIG2;
                DIG2:    w_digit_next = DIG3;
                DIG3:    w_digit_next = DIG0;
                default: w_digit_next = DIG0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Frame snapshot. The bus is sampled only at the end of the digit 3 slot.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_shadow     <= '0;
            r_shadow_dp  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_shadow    <= data_in;
                r_shadow_dp <= dp_in;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-digit leading-zero blanking mask, computed from the snapshot.
    // Because it uses the snapshot, blanking changes only at a frame boundary.
    // -------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        w_lz_mask    = '0;
        w_lz_mask[3] = (r_shadow[15:12] == 4'h0) && !r_shadow_dp[3];
        w_lz_mask[2] = (r_shadow[15:8]  == 8'h0) && !r_shadow_dp[2];
        w_lz_mask[1] = (r_shadow[15:4]  == 12'h0) && !r_shadow_dp[1];
    end
`else
    assign w_lz_mask = '0;
`endif

    // -------------------------------------------------------------------------
    // Next pin values from the current (cnt, digit). They are registered
    // below, which gives one cycle of latency from (cnt, digit) to the pins.
    // -------------------------------------------------------------------------
    assign w_idx    = r_digit;
    assign w_nib    = r_shadow[{w_idx, 2'b00} +: 4];
    assign w_dp_bit = r_shadow_dp[w_idx];

    always_comb begin
        w_an_next  = '1;
        w_seg_next = '1;
        w_dp_next  = 1'b1;
        // The blank window at the head of every slot ensures that one anode
        // is released before the next anode is driven.
        if (r_cnt >= CNT_BLANK) begin
            w_an_next = ~(4'b0001 << w_idx);
            if (!w_lz_mask[w_idx]) begin
                w_seg_next = hex_to_seg(w_nib);
                w_dp_next  = ~w_dp_bit;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_an  <= '1;
            r_seg <= '1;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
